// File: rtl/pattern_detect_sched.sv
// Round-robin scheduler that time-shares one 4-bit serial pattern detector
// among N_REQ requesters: load pattern, stream bits, count matches, report.
module pattern_detect_sched #(
  parameter int N_REQ = 4,
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [4*N_REQ-1:0]     req_pattern,
  input  logic [LEN_W*N_REQ-1:0] req_len,
  input  logic [N_REQ-1:0]       s_valid,
  input  logic [N_REQ-1:0]       s_data,
  output logic [N_REQ-1:0]       s_ready,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic [CNT_W-1:0]       result_count,
  output logic                   result_abort,
  output logic                   busy,
  output logic                   det_load_pattern,
  output logic [3:0]             det_pattern,
  output logic                   det_data_in,
  output logic                   det_input_valid,
  input  logic                   det_match
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] winner;
  logic             found;
  logic [3:0]       pat_q;
  logic [LEN_W-1:0] remain;
  logic [CNT_W-1:0] count;
  logic             aborted;
  logic             drain_second;
  logic [N_REQ-1:0] owner_hot;
  logic             match_en;

  // Round-robin search starting just after the previous owner, wrapping.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    winner = last;
    found  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && req[(int'(last) + k) % N_REQ]) begin
        winner = IDX_W'((int'(last) + k) % N_REQ);
        found  = 1'b1;
      end
    end
  end

  assign match_en = det_match && ((state == S_STREAM) || (state == S_DRAIN));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      owner        <= '0;
      last         <= IDX_W'(N_REQ - 1);
      pat_q        <= '0;
      remain       <= '0;
      count        <= '0;
      aborted      <= 1'b0;
      drain_second <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (match_en && (count != '1)) count <= count + 1'b1;

      case (state)
        S_IDLE: begin
          if (found) begin
            owner   <= winner;
            pat_q   <= req_pattern[4*winner +: 4];
            remain  <= req_len[LEN_W*winner +: LEN_W];
            count   <= '0;
            aborted <= 1'b0;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!req[owner]) begin
            aborted <= 1'b1;
            state   <= S_DONE;
          end else if (remain == '0) begin
            state <= S_DONE;
          end else begin
            state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (!req[owner]) begin
            aborted <= 1'b1;
            state   <= S_DONE;
          end else if (s_valid[owner]) begin
            remain <= remain - 1'b1;
            if (remain == LEN_W'(1)) begin
              drain_second <= 1'b0;
              state        <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (!req[owner]) begin
            aborted <= 1'b1;
            state   <= S_DONE;
          end else if (drain_second) begin
            state <= S_DONE;
          end else begin
            drain_second <= 1'b1;
          end
        end
        S_DONE: begin
          last  <= owner;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode registered state/owner; only the stream path passes through.
  assign owner_hot        = N_REQ'(1) << owner;
  assign busy             = (state != S_IDLE);
  assign grant            = busy ? owner_hot : '0;
  assign s_ready          = (state == S_STREAM) ? owner_hot : '0;
  assign done             = (state == S_DONE) ? owner_hot : '0;
  assign det_load_pattern = (state == S_LOAD);
  assign det_pattern      = (state == S_LOAD) ? pat_q : 4'h0;
  assign det_input_valid  = (state == S_STREAM) && s_valid[owner];
  assign det_data_in      = (state == S_STREAM) && s_data[owner];
  assign result_count     = count;
  assign result_abort     = aborted;

endmodule

// File: tb/tb_pattern_detect_sched.sv
// Self-checking bench for pattern_detect_sched: directed and randomized
// sessions checked against a session-level model of the scheduler.
module tb_pattern_detect_sched;

  localparam int N     = 4;
  localparam int LEN_W = 8;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic [4*N-1:0]   req_pattern;
  logic [LEN_W*N-1:0] req_len;
  logic [N-1:0]     s_valid;
  logic [N-1:0]     s_data;
  logic [N-1:0]     s_ready, grant, done;
  logic [CNT_W-1:0] result_count;
  logic             result_abort, busy, det_load_pattern;
  logic [3:0]       det_pattern;
  logic             det_data_in, det_input_valid;
  logic             det_match;

  logic [N-1:0]     sat_s_ready, sat_grant, sat_done;
  logic [1:0]       sat_result_count;
  logic             sat_result_abort, sat_busy, sat_det_load_pattern;
  logic [3:0]       sat_det_pattern;
  logic             sat_det_data_in, sat_det_input_valid;

  int checks = 0;
  int errors = 0;
  int model_last;

  pattern_detect_sched #(.N_REQ(N), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_pattern(req_pattern), .req_len(req_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .grant(grant), .done(done),
    .result_count(result_count), .result_abort(result_abort), .busy(busy),
    .det_load_pattern(det_load_pattern), .det_pattern(det_pattern),
    .det_data_in(det_data_in), .det_input_valid(det_input_valid), .det_match(det_match)
  );

  // Narrow-counter twin shares all inputs so saturation is visible every session.
  pattern_detect_sched #(.N_REQ(N), .LEN_W(LEN_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req(req), .req_pattern(req_pattern), .req_len(req_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(sat_s_ready), .grant(sat_grant),
    .done(sat_done), .result_count(sat_result_count), .result_abort(sat_result_abort),
    .busy(sat_busy), .det_load_pattern(sat_det_load_pattern),
    .det_pattern(sat_det_pattern), .det_data_in(sat_det_data_in),
    .det_input_valid(sat_det_input_valid), .det_match(det_match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] hot(input int i);
    return 4'(1 << i);
  endfunction

  // One full session for a lone requester, entered and left at a negedge in IDLE.
  // mode: 0 back-to-back, 1 valid toggling 1,0,1,..., 2 random valid.
  task automatic session(input int who, input logic [3:0] pat, input int len,
                         input int mode, input logic [63:0] smask,
                         input logic [1:0] dmask, input int abort_after);
    int cyc, acc, sc, exp_cnt;
    bit aborted, v;
    exp_cnt = 0; aborted = 0; cyc = 0;
    req_pattern[4*who +: 4]     = pat;
    req_len[LEN_W*who +: LEN_W] = LEN_W'(len);
    req       = hot(who);
    s_valid   = 4'($urandom);
    s_data    = 4'($urandom);
    det_match = 1'($urandom);
    #1;
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_ready", 64'(s_ready), 64'(0));
    check("idle_div", 64'(det_input_valid), 64'(0));

    @(negedge clk); cyc++;
    s_valid   = 4'($urandom);
    det_match = 1'($urandom);
    #1;
    check("load_grant", 64'(grant), 64'(hot(who)));
    check("load_strobe", 64'(det_load_pattern), 64'(1));
    check("load_pattern", 64'(det_pattern), 64'(pat));
    check("load_ready", 64'(s_ready), 64'(0));
    check("load_div", 64'(det_input_valid), 64'(0));

    if (len > 0) begin
      acc = 0; sc = 0;
      while (acc < len) begin
        @(negedge clk); cyc++;
        if (acc == abort_after) begin
          req = '0; s_valid = '0; det_match = 1'b0;
          #1 check("abort_ready", 64'(s_ready), 64'(hot(who)));
          aborted = 1;
          break;
        end
        v = (mode == 0) ? 1'b1 : (mode == 1) ? ((sc % 2) == 0) : 1'($urandom);
        s_valid      = 4'($urandom);
        s_valid[who] = v;
        s_data       = 4'($urandom);
        det_match    = (sc < 64) ? smask[sc] : 1'b0;
        if (det_match) exp_cnt++;
        #1;
        check("stream_ready", 64'(s_ready), 64'(hot(who)));
        check("stream_div", 64'(det_input_valid), 64'(v));
        if (v) check("stream_data", 64'(det_data_in), 64'(s_data[who]));
        if (v) acc++;
        sc++;
        if (sc > 200) begin
          checks++; errors++;
          $error("FAIL stream_budget: observed %0d handshakes expected %0d", acc, len);
          break;
        end
      end
      if (!aborted) begin
        for (int d = 0; d < 2; d++) begin
          @(negedge clk); cyc++;
          s_valid   = 4'hF;
          det_match = dmask[d];
          if (det_match) exp_cnt++;
          #1;
          check("drain_ready", 64'(s_ready), 64'(0));
          check("drain_div", 64'(det_input_valid), 64'(0));
          check("drain_grant", 64'(grant), 64'(hot(who)));
          check("drain_done", 64'(done), 64'(0));
        end
      end
    end

    @(negedge clk); cyc++;
    det_match = 1'b1;
    s_valid   = '0;
    #1;
    check("done_pulse", 64'(done), 64'(hot(who)));
    check("done_grant", 64'(grant), 64'(hot(who)));
    check("done_count", 64'(result_count), 64'(exp_cnt > 255 ? 255 : exp_cnt));
    check("done_sat_count", 64'(sat_result_count), 64'(exp_cnt > 3 ? 3 : exp_cnt));
    check("done_abort", 64'(result_abort), 64'(aborted));
    if (!aborted && (mode == 0 || len == 0))
      check("done_latency", 64'(cyc), 64'(len == 0 ? 2 : len + 4));
    req = '0;
    model_last = who;

    @(negedge clk);
    det_match = 1'b0;
    #1;
    check("post_done", 64'(done), 64'(0));
    check("post_grant", 64'(grant), 64'(0));
    check("post_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    int prev, expw, waitc, who, len, mode, ab;
    logic [3:0] served, g;

    rst = 1'b0; req = '0; req_pattern = '0; req_len = '0;
    s_valid = '0; s_data = '0; det_match = 1'b0;
    model_last = N - 1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_ready", 64'(s_ready), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_count", 64'(result_count), 64'(0));
    check("rst_abort", 64'(result_abort), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_load", 64'(det_load_pattern), 64'(0));
    check("rst_pattern", 64'(det_pattern), 64'(0));
    check("rst_div", 64'(det_input_valid), 64'(0));
    rst = 1'b1;
    @(negedge clk);

    // Round-robin with every requester holding req through its own done.
    req_len = {4{8'd4}}; req_pattern = 16'h1234; s_valid = 4'hF; req = 4'hF;
    prev = model_last; served = '0;
    for (int s = 0; s < 5; s++) begin
      expw = (prev + 1) % N;
      waitc = 0;
      do begin @(negedge clk); #1; waitc++; end while (grant == '0 && waitc < 20);
      g = grant;
      check("rr_grant", 64'(g), 64'(hot(expw)));
      check("rr_fresh", 64'(served & g), 64'(0));
      served |= g;
      if (served == 4'hF) served = '0;
      waitc = 0;
      while (done == '0 && waitc < 20) begin @(negedge clk); #1; waitc++; end
      check("rr_done", 64'(done), 64'(g));
      check("rr_count", 64'(result_count), 64'(0));
      if (s == 4) begin req = '0; s_valid = '0; end
      prev = expw;
    end
    @(negedge clk); #1;
    check("rr_idle", 64'(grant), 64'(0));
    model_last = prev;

    // Directed sessions.
    session(0, 4'b1011, 8, 0, 64'h90, 2'b01, -1);
    session(3, 4'h6, 6, 1, 64'h0, 2'b00, -1);
    session(1, 4'h5, 0, 0, 64'h0, 2'b00, -1);
    session(2, 4'hC, 8, 0, 64'h1F, 2'b00, -1);
    session(2, 4'h3, 10, 0, 64'h2, 2'b00, 3);

    // Randomized sessions.
    for (int r = 0; r < 12; r++) begin
      who  = $urandom_range(0, N - 1);
      len  = $urandom_range(0, 20);
      mode = $urandom_range(0, 2);
      ab   = (len > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : -1;
      session(who, 4'($urandom), len, mode, {$urandom, $urandom}, 2'($urandom), ab);
    end

    // Reset mid-stream: the pointer must return to requester 0 first.
    session(1, 4'hA, 1, 0, 64'h0, 2'b00, -1);
    req_len[LEN_W*1 +: LEN_W] = 8'd10;
    req = 4'b0010; s_valid = 4'hF;
    repeat (4) @(negedge clk);
    #1 check("pre_rst_ready", 64'(s_ready), 64'(4'b0010));
    rst = 1'b0;
    #1;
    check("mid_rst_grant", 64'(grant), 64'(0));
    check("mid_rst_ready", 64'(s_ready), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    check("mid_rst_count", 64'(result_count), 64'(0));
    check("mid_rst_abort", 64'(result_abort), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_load", 64'(det_load_pattern), 64'(0));
    check("mid_rst_pattern", 64'(det_pattern), 64'(0));
    check("mid_rst_div", 64'(det_input_valid), 64'(0));
    @(negedge clk);
    rst = 1'b1; req = 4'b0101;
    @(negedge clk); #1;
    check("rst_first_winner", 64'(grant), 64'(4'b0001));
    rst = 1'b0; req = '0;
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
